// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle sequencer.
//   - RV32 opcode constants handled by the sequencer
//   - state_t  : sequencer state encoding (also visible on state_o)
//   - alu_op_t : ALUOp encoding driven to the ALU decoder
//   - pc_src_t : PC source mux select
//   - is_legal : opcode legality test used in DECODE
package ctrl_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5,
        S_BUSERR = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ALU_R  = 2'b00,
        ALU_I  = 2'b01,
        ALU_LS = 2'b10,
        ALU_BR = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JAL    = 2'b10
    } pc_src_t;

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LD) ||
               (op == OP_ST) || (op == OP_BR) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: shared memory port between the sequencer and memory.
//   mem_req   : access request (driven by the sequencer)
//   mem_we    : access is a write
//   iord      : address select, 0 = PC, 1 = ALU result
//   mem_ready : memory completes the current access this cycle
//
// Handshake: an access completes on a rising edge where mem_req and
// mem_ready are both 1. Once raised, mem_req stays high until completion
// (no withdrawal) and iord/mem_we stay stable meanwhile. mem_ready is
// ignored while mem_req is 0. mem_ready in the first request cycle
// (zero-wait) is legal.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mem_watchdog.sv
// mem_watchdog: counts cycles a memory request has waited without mem_ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear the count (sequencer state change)
//   wait_i     : request pending and not completing this cycle
//   expire     : count has reached TIMEOUT-1 and the request is still waiting;
//                the sequencer abandons the access on the next edge
// TIMEOUT = 0 disables the watchdog (expire stays 0).
module mem_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic wait_i,
    output logic expire
);

    localparam int  CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit  EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (wait_i && (count != LAST)) begin
            // Saturate at LAST so a disabled watchdog never wraps into a match.
            count <= count + CW'(1);
        end
    end

    assign expire = EN && wait_i && (count == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for the RV32 datapath.
// Steps each instruction through FETCH, DECODE, EXEC, optional MEM and
// optional WB, sharing one memory port between fetch and data access.
//   clk, rst_n  : clock, asynchronous active-low reset
//   opcode      : IR[6:0], valid from DECODE onward
//   alu_zero    : ALU zero flag, used by branches in EXEC
//   bus         : memory port (mem_req, mem_we, iord, mem_ready)
//   ir_we       : load IR and latch old_pc
//   pc_we/pc_src: PC write enable and source select
//   reg_we      : register-file write, mem_to_reg selects memory data
//   alu_src_b   : ALU operand B is the immediate
//   alu_op      : ALUOp to the ALU decoder
//   state_o     : current sequencer state
//   illegal     : sticky illegal-opcode flag (TRAP)
//   bus_err     : sticky memory-timeout flag (BUSERR)
//   instret     : retired-instruction count, wraps
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic                 alu_zero,
    multicycle_ctrl_if.master    bus,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_src,
    output logic                 reg_we,
    output logic                 mem_to_reg,
    output logic                 alu_src_b,
    output logic [1:0]           alu_op,
    output logic [2:0]           state_o,
    output logic                 illegal,
    output logic                 bus_err,
    output logic [INSTRET_W-1:0] instret
);

    state_t  state, state_n;
    alu_op_t alu_op_c;
    pc_src_t pc_src_c;
    logic    req_phase;
    logic    mem_we_c, iord_c;
    logic    retire, set_illegal;
    logic    wd_clr, wd_expire;

    // Requesting states. Gated by rst_n so mem_req drops the moment reset
    // asserts, even though the state register already reads FETCH.
    assign req_phase = rst_n && ((state == S_FETCH) || (state == S_MEM));

    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wd_clr),
        .wait_i (req_phase && !bus.mem_ready),
        .expire (wd_expire)
    );

    assign wd_clr = (state_n != state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
            bus_err <= 1'b0;
            instret <= '0;
        end else begin
            state <= state_n;
            if (set_illegal) illegal <= 1'b1;
            if ((state_n == S_BUSERR) && (state != S_BUSERR)) bus_err <= 1'b1;
            if (retire) instret <= instret + INSTRET_W'(1);
        end
    end

    always_comb begin
        state_n     = state;
        mem_we_c    = 1'b0;
        iord_c      = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src_c    = PC_PLUS4;
        reg_we      = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_b   = 1'b0;
        alu_op_c    = ALU_R;
        retire      = 1'b0;
        set_illegal = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_n = S_DECODE;
                    end else if (wd_expire) begin
                        state_n = S_BUSERR;
                    end
                end
                S_DECODE: begin
                    if (is_legal(opcode)) begin
                        state_n = S_EXEC;
                    end else begin
                        state_n     = S_TRAP;
                        set_illegal = 1'b1;
                    end
                end
                S_EXEC: begin
                    case (opcode)
                        OP_R: begin
                            alu_op_c = ALU_R;
                            state_n  = S_WB;
                        end
                        OP_I: begin
                            alu_op_c  = ALU_I;
                            alu_src_b = 1'b1;
                            state_n   = S_WB;
                        end
                        OP_LD, OP_ST: begin
                            alu_op_c  = ALU_LS;
                            alu_src_b = 1'b1;
                            state_n   = S_MEM;
                        end
                        OP_BR: begin
                            alu_op_c = ALU_BR;
                            pc_we    = alu_zero;
                            pc_src_c = PC_BRANCH;
                            retire   = 1'b1;
                            state_n  = S_FETCH;
                        end
                        OP_JAL: begin
                            pc_we    = 1'b1;
                            pc_src_c = PC_JAL;
                            retire   = 1'b1;
                            state_n  = S_FETCH;
                        end
                        default: state_n = S_TRAP;
                    endcase
                end
                S_MEM: begin
                    iord_c   = 1'b1;
                    mem_we_c = (opcode == OP_ST);
                    if (bus.mem_ready) begin
                        if (opcode == OP_ST) begin
                            retire  = 1'b1;
                            state_n = S_FETCH;
                        end else begin
                            state_n = S_WB;
                        end
                    end else if (wd_expire) begin
                        state_n = S_BUSERR;
                    end
                end
                S_WB: begin
                    reg_we     = 1'b1;
                    mem_to_reg = (opcode == OP_LD);
                    retire     = 1'b1;
                    state_n    = S_FETCH;
                end
                default: state_n = state;   // TRAP / BUSERR hold until reset
            endcase
        end
    end

    assign bus.mem_req = req_phase;
    assign bus.mem_we  = mem_we_c;
    assign bus.iord    = iord_c;
    assign pc_src      = pc_src_c;
    assign alu_op      = alu_op_c;
    assign state_o     = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  localparam int TO = 8;
  localparam int IW = 4;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] I_OP   = 7'b0010011;
  localparam logic [6:0] LD_OP  = 7'b0000011;
  localparam logic [6:0] ST_OP  = 7'b0100011;
  localparam logic [6:0] BR_OP  = 7'b1100011;
  localparam logic [6:0] JAL_OP = 7'b1101111;

  logic          clk;
  logic          rst_n;
  logic [6:0]    opcode;
  logic          alu_zero;
  logic          ir_we, pc_we, reg_we, mem_to_reg, alu_src_b, illegal, bus_err;
  logic [1:0]    pc_src, alu_op;
  logic [2:0]    state_o;
  logic [IW-1:0] instret;
  logic [11:0]   ctrl_now;

  multicycle_ctrl_if mif();

  multicycle_ctrl #(.TIMEOUT(TO), .INSTRET_W(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .alu_zero   (alu_zero),
    .bus        (mif),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .reg_we     (reg_we),
    .mem_to_reg (mem_to_reg),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .state_o    (state_o),
    .illegal    (illegal),
    .bus_err    (bus_err),
    .instret    (instret)
  );

  assign ctrl_now = {mif.mem_req, mif.mem_we, mif.iord, ir_we, pc_we, pc_src,
                     reg_we, mem_to_reg, alu_src_b, alu_op};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // one entry per clock cycle: {state[2:0], ctrl[11:0]} plus the inputs to drive
  logic [14:0] exp_q[$];
  logic        rdy_q[$];
  logic        zero_q[$];
  logic [6:0]  op_q[$];
  int          total = 0;
  int          bad = 0;
  int          model_ret = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] mk(input logic [2:0] st, input logic req, input logic we,
                                     input logic io, input logic irw, input logic pcw,
                                     input logic [1:0] pcs, input logic rw, input logic m2r,
                                     input logic sb, input logic [1:0] ao);
    return {st, req, we, io, irw, pcw, pcs, rw, m2r, sb, ao};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit legal_op(input logic [6:0] op);
    return op inside {R_OP, I_OP, LD_OP, ST_OP, BR_OP, JAL_OP};
  endfunction

  task automatic push(input logic [14:0] e, input logic r, input logic z, input logic [6:0] o);
    exp_q.push_back(e);
    rdy_q.push_back(r);
    zero_q.push_back(z);
    op_q.push_back(o);
  endtask

  // ---------------- reference model: cycle sequence per instruction ----------------
  task automatic add_fetch(input int fw);
    logic [6:0] junk;
    junk = 7'($urandom);
    for (int i = 0; i <= fw; i++) begin
      logic r;
      r = (i == fw);
      push(mk(3'd0, 1'b1, 1'b0, 1'b0, r, r, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00), r, rb(), junk);
    end
  endtask

  task automatic add_hang_fetch();
    for (int i = 0; i < TO; i++)
      push(mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00), 1'b0, rb(), 7'h00);
  endtask

  task automatic add_idle(input logic [2:0] st, input int n, input logic [6:0] op);
    for (int i = 0; i < n; i++)
      push(mk(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00), rb(), rb(), op);
  endtask

  task automatic add_instr(input logic [6:0] op, input int fw, input int mw, input logic z);
    logic is_ld, is_st;
    is_ld = (op == LD_OP);
    is_st = (op == ST_OP);
    add_fetch(fw);
    add_idle(3'd1, 1, op);
    case (op)
      R_OP:   push(mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00), rb(), rb(), op);
      I_OP:   push(mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b01), rb(), rb(), op);
      BR_OP:  push(mk(3'd2, 0, 0, 0, 0, z, 2'b01, 0, 0, 0, 2'b11), rb(), z, op);
      JAL_OP: push(mk(3'd2, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 2'b00), rb(), rb(), op);
      default: begin
        push(mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b10), rb(), rb(), op);
        for (int i = 0; i <= mw; i++)
          push(mk(3'd3, 1, is_st, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00), (i == mw), rb(), op);
      end
    endcase
    if (op inside {R_OP, I_OP, LD_OP})
      push(mk(3'd4, 0, 0, 0, 0, 0, 2'b00, 1, is_ld, 0, 2'b00), rb(), rb(), op);
    model_ret++;
  endtask

  // ---------------- driver ----------------
  // entered and left at a falling edge; inputs change there, outputs sampled 1ns later
  task automatic run_q();
    logic [14:0] e;
    while (exp_q.size() > 0) begin
      e            = exp_q.pop_front();
      mif.mem_ready = rdy_q.pop_front();
      alu_zero     = zero_q.pop_front();
      opcode       = op_q.pop_front();
      #1;
      check_val("state", 32'(state_o), 32'(e[14:12]));
      check_val("ctrl", 32'(ctrl_now), 32'(e[11:0]));
      @(negedge clk);
    end
  endtask

  task automatic check_ret(input string tag);
    check_val(tag, 32'(instret), 32'(model_ret % (1 << IW)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mif.mem_ready = 1'b0;
    model_ret = 0;
    #1;
    check_val("rst_state", 32'(state_o), 32'd0);
    check_val("rst_ctrl", 32'(ctrl_now), 32'd0);
    check_ret("rst_instret");
    check_val("rst_illegal", 32'(illegal), 32'd0);
    check_val("rst_bus_err", 32'(bus_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("post_rst_state", 32'(state_o), 32'd0);
    check_ret("post_rst_instret");
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic z);
    add_instr(op, fw, mw, z);
    run_q();
    check_ret("instret");
    check_val("illegal", 32'(illegal), 32'd0);
    check_val("bus_err", 32'(bus_err), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] ops[6];
    logic [6:0] bad_op;
    ops[0] = R_OP; ops[1] = I_OP; ops[2] = LD_OP;
    ops[3] = ST_OP; ops[4] = BR_OP; ops[5] = JAL_OP;
    rst_n = 1'b0;
    opcode = 7'h00;
    alu_zero = 1'b0;
    mif.mem_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // directed: R zero-wait, load with 3 waits, branches both ways, jal, fetch ready in 8th cycle
    run_instr(R_OP, 0, 0, 1'b0);
    run_instr(LD_OP, 0, 3, 1'b0);
    run_instr(BR_OP, 0, 0, 1'b1);
    run_instr(BR_OP, 0, 0, 1'b0);
    run_instr(JAL_OP, 0, 0, 1'b0);
    run_instr(I_OP, TO - 1, 0, 1'b0);
    run_instr(ST_OP, 0, TO - 1, 1'b0);

    // randomized legal instruction stream (instret wraps at 2^IW)
    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, TO - 1),
                $urandom_range(0, TO - 1), rb());

    // reset in the middle of a waiting store: access abandoned, not counted
    add_fetch(1);
    add_idle(3'd1, 1, ST_OP);
    push(mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b10), 1'b0, 1'b0, ST_OP);
    for (int i = 0; i < 3; i++)
      push(mk(3'd3, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00), 1'b0, 1'b0, ST_OP);
    run_q();
    do_reset();
    run_instr(R_OP, 0, 0, 1'b0);

    // illegal opcodes: terminal TRAP, no memory traffic, instret frozen
    for (int t = 0; t < 2; t++) begin
      if (t == 0) bad_op = 7'h7f;
      else begin
        do bad_op = 7'($urandom_range(0, 127)); while (legal_op(bad_op));
      end
      run_instr(ops[$urandom_range(0, 5)], 0, 0, 1'b0);
      add_fetch($urandom_range(0, 3));
      add_idle(3'd1, 1, bad_op);
      add_idle(3'd5, 22, bad_op);
      run_q();
      check_val("trap_illegal", 32'(illegal), 32'd1);
      check_val("trap_bus_err", 32'(bus_err), 32'd0);
      check_ret("trap_instret");
      do_reset();
    end

    // fetch never completes: BUSERR after TO cycles
    run_instr(JAL_OP, 0, 0, 1'b0);
    add_hang_fetch();
    add_idle(3'd6, 6, 7'h00);
    run_q();
    check_val("fetch_to_bus_err", 32'(bus_err), 32'd1);
    check_val("fetch_to_illegal", 32'(illegal), 32'd0);
    check_ret("fetch_to_instret");
    do_reset();

    // load data access never completes
    run_instr(I_OP, 0, 0, 1'b0);
    add_fetch(0);
    add_idle(3'd1, 1, LD_OP);
    push(mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b10), rb(), rb(), LD_OP);
    for (int i = 0; i < TO; i++)
      push(mk(3'd3, 1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00), 1'b0, rb(), LD_OP);
    add_idle(3'd6, 6, LD_OP);
    run_q();
    check_val("mem_to_bus_err", 32'(bus_err), 32'd1);
    check_ret("mem_to_instret");
    do_reset();
    run_instr(LD_OP, 2, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32 datapath. It steps each instruction through FETCH, DECODE, EXEC, optional MEM, and optional WB, and drives the datapath enables and muxes.
- It shares one memory port between instruction fetch and data access through a req/ready handshake, with a watchdog on that port.
- Sits between the instruction register (IR) opcode field and the PC, IR, register-file, ALU and memory interface. Uses the team's ALUOp encoding.

Parameters:
- TIMEOUT, 16: max cycles mem_req may wait for mem_ready; 0 disables the watchdog.
- INSTRET_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- alu_zero  in  1  ALU zero flag; sampled in EXEC for branches.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  access is a write.
- iord  out  1  address select: 0 = PC, 1 = ALU result.
- ir_we  out  1  load IR and latch old_pc.
- pc_we  out  1  PC write enable.
- pc_src  out  2  PC source: 00 = pc+4, 01 = branch target, 10 = jal target.
- reg_we  out  1  register-file write.
- mem_to_reg  out  1  writeback select: 1 = memory data.
- alu_src_b  out  1  ALU operand B: 1 = immediate.
- alu_op  out  2  ALU operation: 00 = R, 01 = I, 10 = ld/st, 11 = branch.
- state_o  out  3  current state.
- illegal  out  1  sticky illegal-opcode flag.
- bus_err  out  1  sticky memory-timeout flag.
- instret  out  INSTRET_W  retired-instruction count.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5, BUSERR=6.
- Outputs are combinational from state, opcode and alu_zero. Any output not listed for a state is 0.
- While rst_n=0:
  - state = FETCH.
  - All control outputs = 0; mem_req must drop immediately on rst_n assertion.
  - illegal = bus_err = 0; instret = 0; watchdog count = 0.
  - Reset mid-access abandons the access; no completion is expected.
- FETCH:
  - Outputs: mem_req = 1, iord = 0.
  - On mem_ready: ir_we = 1, pc_we = 1, pc_src = 00; go to DECODE. Otherwise hold.
- DECODE:
  - Opcode 0110011, 0010011, 0000011, 0100011, 1100011 or 1101111: go to EXEC.
  - Any other opcode: go to TRAP and set illegal.
- EXEC:
  - 0110011: alu_op = 00, alu_src_b = 0; go to WB.
  - 0010011: alu_op = 01, alu_src_b = 1; go to WB.
  - 0000011 / 0100011: alu_op = 10, alu_src_b = 1; go to MEM.
  - 1100011: alu_op = 11, alu_src_b = 0; pc_we = alu_zero, pc_src = 01; retire; go to FETCH.
  - 1101111: pc_we = 1, pc_src = 10; no link write (reg_we = 0); retire; go to FETCH.
- MEM:
  - Outputs: mem_req = 1, iord = 1, mem_we = (opcode == 0100011).
  - Load, on mem_ready: go to WB.
  - Store, on mem_ready: retire; go to FETCH.
- WB:
  - Outputs: reg_we = 1, mem_to_reg = (opcode == 0000011).
  - Retire; go to FETCH.
- TRAP / BUSERR:
  - Terminal; all control outputs 0 until reset.
  - bus_err is set when entering BUSERR.
- Handshake rules:
  - mem_req stays high until mem_ready; no withdrawal.
  - Address and mem_we are stable for the whole request.
  - mem_ready is ignored when mem_req = 0.
  - Zero-wait (mem_ready in the first cycle of the request) is legal.
- Watchdog:
  - Counter clears on every state change.
  - Increments each cycle that mem_req = 1 and mem_ready = 0.
  - When the count reaches TIMEOUT-1 with mem_ready still 0, go to BUSERR on the next edge.
  - mem_ready in that same cycle wins: the access completes normally.
- Retire: instret += 1 on the retiring edge, wrapping modulo 2^INSTRET_W.
- Cycle counts with zero-wait memory: R/I = 4, load = 5, store = 4, branch/jal = 3.

Decomposition:
- Package ctrl_pkg:
  - Opcode localparams: OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL.
  - state_t enum (3-bit, encoding above).
  - alu_op_t enum.
  - pc_src_t enum.
- Sub-module mem_watchdog:
  - Parameter TIMEOUT.
  - Inputs: clk, rst_n, clr, wait_i.
  - Output: expire.
- The FSM stays in multicycle_ctrl.

Test Plan:
- R-type (opcode 0110011), mem_ready held at 1: state_o sequence 0, 1, 2, 4, 0; reg_we = 1 only in WB; instret 0 -> 1 after 4 cycles.
- Load, 3 wait states in MEM: mem_req = 1, iord = 1 for 4 cycles; WB has mem_to_reg = 1, reg_we = 1; total 8 cycles; instret + 1.
- Branch 1100011:
  - alu_zero = 1: pc_we = 1, pc_src = 01 in EXEC.
  - alu_zero = 0: pc_we = 0.
  - Either case: back in FETCH after 3 cycles.
- Opcode 1111111: DECODE -> TRAP; illegal = 1; mem_req stays 0 for 20+ cycles; instret unchanged.
- TIMEOUT = 8, mem_ready never asserted in FETCH:
  - bus_err = 1 and state_o = 6 after 8 cycles; mem_req = 0 afterwards.
  - Repeat with mem_ready arriving in the 8th cycle: normal completion, no bus_err.
- rst_n pulsed low mid-MEM store: mem_req = 0 at once; after release, state_o = 0 and instret = 0; no write is counted.
